bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double dabble (shift-right / subtract-3), one bit per clock.
- Companion to the combinational binary-to-BCD path: converts operator- or display-side decimal values (6 BCD digits) back into a 20-bit binary word for the ADC/DAC control logic.
- Start/busy/done handshake; result is registered and held until the next completed conversion.

---
 rtl/bcd_to_bin_pkg.sv | 28 ++
 rtl/bcd_digit_corr.sv | 18 +
 rtl/bcd_to_bin_seq.sv | 133 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_pkg.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_pkg
// Shared constants for the sequential BCD-to-binary converter:
//   - FSM state encoding (IDLE / CONV / FIN) as legacy-compatible constants
//   - digit width and reverse-double-dabble correction constants
//   - helper that sizes the iteration counter
// -----------------------------------------------------------------------------
package bcd_to_bin_pkg;

  localparam int DIGIT_W = 4;

  // A digit that reads 8 or more after a right shift held a carry from the
  // digit above; it is worth 5 in the lower digit, not 8, so subtract 3.
  localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] CORR_SUB    = 4'd3;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX   = 4'd9;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  // Counter must hold the value BIN_W itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// -----------------------------------------------------------------------------
// bcd_digit_corr
// Combinational per-digit correction step of reverse double dabble:
// a 4-bit digit >= 8 has 3 subtracted (4-bit wraparound), otherwise passes.
// Ports:
//   digit      in  [3:0]  shifted digit
//   corrected  out [3:0]  digit after correction
// -----------------------------------------------------------------------------
module bcd_digit_corr
  import bcd_to_bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] corrected
);

  assign corrected = (digit >= CORR_THRESH) ? (digit - CORR_SUB) : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential BCD-to-binary converter (reverse double dabble, one bit per
// clock). Converts DIGITS packed BCD digits into a BIN_W-bit binary word.
//
// Ports:
//   iCLK     in   1          system clock, rising edge
//   iRST_N   in   1          asynchronous active-low reset
//   iSTART   in   1          conversion request, sampled only in IDLE
//   iBCD     in   4*DIGITS   packed BCD operand, digit 0 in [3:0]
//   oBIN     out  BIN_W      result, updated only on the oDONE cycle
//   oBUSY    out  1          high while converting
//   oDONE    out  1          one-cycle pulse when oBIN is updated
//   oERR     out  1          one-cycle pulse on a rejected (non-BCD) request
//
// Optional feature macro: BCD_TO_BIN_DIGIT_CHECK_EN
//   defined   - a request with any digit > 9 is rejected and pulses oERR
//   undefined - oERR is tied low; any nibble pattern is run through the
//               datapath unchanged
// -----------------------------------------------------------------------------
module bcd_to_bin_seq
  import bcd_to_bin_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic                      iSTART,
  input  logic [DIGIT_W*DIGITS-1:0] iBCD,
  output logic [BIN_W-1:0]          oBIN,
  output logic                      oBUSY,
  output logic                      oDONE,
  output logic                      oERR
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = cnt_width(BIN_W);

  state_t             state;
  logic [BCD_W-1:0]   digit_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   digit_sh;
  logic [BCD_W-1:0]   digit_next;
  logic [BIN_W-1:0]   bin_sh;
  logic               digit_bad;

  // Shift {digit_reg, bin_reg} right by one: the digit LSB enters the
  // binary MSB, and the digit register gets a zero at its top.
  assign digit_sh = {1'b0, digit_reg[BCD_W-1:1]};
  assign bin_sh   = {digit_reg[0], bin_reg[BIN_W-1:1]};

  // Independent 4-bit correction per digit; no borrow crosses digits.
  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit     (digit_sh[g*DIGIT_W +: DIGIT_W]),
      .corrected (digit_next[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    digit_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (iBCD[k*DIGIT_W +: DIGIT_W] > DIGIT_MAX) digit_bad = 1'b1;
    end
  end

  // Rejection is decided on the same edge that would have accepted the
  // request, so the pulse appears in the cycle right after that edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oERR <= 1'b0;
    end else begin
      oERR <= (state == ST_IDLE) && iSTART && digit_bad;
    end
  end
`else
  assign digit_bad = 1'b0;
  assign oERR      = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      digit_reg <= '0;
      bin_reg   <= '0;
      cnt       <= '0;
      oBIN      <= '0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iSTART && !digit_bad) begin
            digit_reg <= iBCD;
            bin_reg   <= '0;
            cnt       <= CNT_W'(BIN_W);
            oBUSY     <= 1'b1;
            state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          digit_reg <= digit_next;
          bin_reg   <= bin_sh;
          cnt       <= cnt - CNT_W'(1);
          // Last shift: busy drops as FIN is entered, so a start seen in
          // FIN is ignored and the next accept is the edge after oDONE.
          if (cnt == CNT_W'(1)) begin
            oBUSY <= 1'b0;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          oBIN  <= bin_reg;
          oDONE <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
// Self-checking bench for bcd_to_bin_seq. A cycle-level behavioural model
// (decimal arithmetic plus a "cycles since accept" timer) predicts oBIN,
// oBUSY, oDONE and oERR; a compare process checks them on every falling
// edge. Directed vectors additionally pin literal results, latency and
// busy length. Honours BCD_TO_BIN_DIGIT_CHECK_EN if defined.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 6;
  localparam int BIN_W  = 20;
  localparam int LAT    = BIN_W + 1;

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic              iCLK;
  logic              iRST_N;
  logic              iSTART;
  logic [4*DIGITS-1:0] iBCD;
  logic [BIN_W-1:0]  oBIN;
  logic              oBUSY;
  logic              oDONE;
  logic              oERR;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iSTART (iSTART),
    .iBCD   (iBCD),
    .oBIN   (oBIN),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oERR   (oERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word.
  function automatic logic [BIN_W-1:0] dec(input logic [4*DIGITS-1:0] v);
    int s;
    s = 0;
    for (int k = DIGITS - 1; k >= 0; k--) s = s * 10 + int'(v[4*k +: 4]);
    return BIN_W'(s);
  endfunction

  function automatic bit has_bad(input logic [4*DIGITS-1:0] v);
    bit b;
    b = 1'b0;
    for (int k = 0; k < DIGITS; k++) if (v[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // ---------------- behavioural model ----------------
  int               m_t = -1;      // cycles since accepting edge, -1 when idle
  logic [BIN_W-1:0] m_pending = '0;
  logic [BIN_W-1:0] m_bin = '0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic             m_err  = 1'b0;

  initial begin
    forever begin
      @(posedge iCLK or negedge iRST_N);
      if (!iRST_N) begin
        m_t = -1; m_bin = '0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      end else begin
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_t >= 0) begin
          m_t++;
          if (m_t == LAT) begin
            m_done = 1'b1;
            m_bin  = m_pending;
            m_t    = -1;
          end
        end else if (iSTART) begin
          if (CHECK_EN && has_bad(iBCD)) begin
            m_err = 1'b1;
          end else begin
            m_t       = 0;
            m_pending = dec(iBCD);
          end
        end
        m_busy = (m_t >= 0) && (m_t < BIN_W);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge iCLK);
      if (iRST_N) begin
        check("cyc oBIN",  32'(oBIN),  32'(m_bin));
        check("cyc oBUSY", 32'(oBUSY), 32'(m_busy));
        check("cyc oDONE", 32'(oDONE), 32'(m_done));
        check("cyc oERR",  32'(oERR),  32'(m_err));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; request is seen by exactly one rising edge.
  task automatic start_pulse(input logic [4*DIGITS-1:0] v);
    iBCD   = v;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  // Called at the falling edge just after the accepting edge. Returns the
  // number of falling edges until oDONE is seen and the busy cycle count.
  task automatic wait_done(input string name, output int lat, output int busy_n);
    bit ok;
    ok = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (oDONE) ok = 1'b1;
      else begin
        if (oBUSY) busy_n++;
        lat++;
        @(negedge iCLK);
      end
    end
    check({name, " done seen"}, 32'(ok), 32'd1);
  endtask

  task automatic run_conv(input string name, input logic [4*DIGITS-1:0] v,
                          input logic [BIN_W-1:0] exp);
    int lat, busy_n;
    start_pulse(v);
    wait_done(name, lat, busy_n);
    check({name, " oBIN"}, 32'(oBIN), 32'(exp));
    check({name, " latency"}, 32'(lat), 32'(LAT));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, busy_n, done_n;
    logic [4*DIGITS-1:0] v;

    iRST_N = 1'b0;
    iSTART = 1'b0;
    iBCD   = '0;
    repeat (3) @(negedge iCLK);
    check("reset oBIN",  32'(oBIN),  32'd0);
    check("reset oBUSY", 32'(oBUSY), 32'd0);
    check("reset oDONE", 32'(oDONE), 32'd0);
    check("reset oERR",  32'(oERR),  32'd0);
    #2 iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // Maximum value: busy length and latency.
    start_pulse(24'h999999);
    wait_done("max", lat, busy_n);
    check("max oBIN", 32'(oBIN), 32'hF423F);
    check("max latency", 32'(lat), 32'(LAT));
    check("max busy cycles", 32'(busy_n), 32'(BIN_W));
    check("max oERR", 32'(oERR), 32'd0);

    run_conv("v123456", 24'h123456, 20'h1E240);
    run_conv("zero",    24'h000000, 20'h00000);
    run_conv("one",     24'h000001, 20'h00001);

    // Back-to-back: start held high through the first conversion with a
    // different operand; it must be taken only after the first oDONE.
    iBCD   = 24'h123456;
    iSTART = 1'b1;
    @(negedge iCLK);
    iBCD   = 24'h000010;
    wait_done("b2b first", lat, busy_n);
    check("b2b first oBIN", 32'(oBIN), 32'h1E240);
    @(negedge iCLK);
    check("b2b oBIN held", 32'(oBIN), 32'h1E240);
    check("b2b second busy", 32'(oBUSY), 32'd1);
    wait_done("b2b second", lat, busy_n);
    check("b2b second oBIN", 32'(oBIN), 32'h0000A);
    iSTART = 1'b0;
    repeat (3) @(negedge iCLK);

    // Reset in the middle of a conversion.
    start_pulse(24'h999999);
    repeat (9) @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    check("async rst oBIN",  32'(oBIN),  32'd0);
    check("async rst oBUSY", 32'(oBUSY), 32'd0);
    check("async rst oDONE", 32'(oDONE), 32'd0);
    check("async rst oERR",  32'(oERR),  32'd0);
    @(negedge iCLK);
    #2 iRST_N = 1'b1;
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge iCLK);
      if (oDONE) done_n++;
    end
    check("no done after rst", 32'(done_n), 32'd0);
    run_conv("after rst", 24'h000042, 20'h0002A);

    // Non-BCD digit.
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    start_pulse(24'h00000A);
    check("bad digit oERR", 32'(oERR), 32'd1);
    check("bad digit oBUSY", 32'(oBUSY), 32'd0);
    @(negedge iCLK);
    check("bad digit oERR pulse", 32'(oERR), 32'd0);
    check("bad digit oBIN kept", 32'(oBIN), 32'h0002A);
    repeat (25) @(negedge iCLK);
    check("bad digit no done oBIN", 32'(oBIN), 32'h0002A);
`else
    run_conv("bad digit", 24'h00000A, 20'h0000A);
    check("bad digit oERR", 32'(oERR), 32'd0);
`endif

    // Sweep of valid values, issued back to back.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < DIGITS; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
      start_pulse(v);
      wait_done("sweep", lat, busy_n);
      check("sweep oBIN", 32'(oBIN), 32'(dec(v)));
      check("sweep latency", 32'(lat), 32'(LAT));
    end

    repeat (4) @(negedge iCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
